mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Core-side initiator for the single-port byte-addressable unified memory (Memory).
//  Arbitrates instruction fetch and load/store requests onto the one memory port.
//  Drives MemRead/MemWrite/func3/Addr/Data_in, captures combinational read data and answers the core with ready pulses.
//  Sits between the datapath (PC/ALU/regfile) and the memory; checks alignment and range before any access.
// PARAMETERS
//  ADDR_W   8   memory address width; the memory holds 2**ADDR_W bytes
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-low reset
//  if_req      in   1       fetch request; held until if_ready
//  if_addr     in   32      fetch byte address (PC)
//  if_ready    out  1       one-cycle pulse: fetch done
//  if_err      out  1       valid with if_ready: misaligned or out-of-range PC
//  if_instr    out  32      fetched word; held until the next fetch completes
//  d_req       in   1       data request; held until d_ready
//  d_we        in   1       1=store, 0=load
//  d_func3     in   3       RV32 load/store funct3
//  d_addr      in   32      data byte address (ALU result)
//  d_wdata     in   32      store data
//  d_ready     out  1       one-cycle pulse: data access done
//  d_err       out  1       valid with d_ready: access rejected, memory untouched
//  d_rdata     out  32      load result, already extended by memory; held until the next load
//  mem_read    out  1       to memory MemRead
//  mem_write   out  1       to memory MemWrite
//  mem_func3   out  3       to memory func3
//  mem_addr    out  ADDR_W  to memory Addr
//  mem_wdata   out  32      to memory Data_in
//  mem_rdata   in   32      from memory Data_out (combinational)
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; all outputs 0, including if_instr and d_rdata.
//  FSM states: IDLE, ACCESS, RESP.
//  IDLE:
//   - samples requests at posedge; d_req has priority over if_req (older instruction).
//   - checked request -> ACCESS; request with error -> RESP with err set, no memory access.
//   - no request -> stays in IDLE.
//  ACCESS (exactly 1 cycle), load/fetch:
//   - drive mem_read=1 and mem_addr=addr[ADDR_W-1:0].
//   - mem_func3 = d_func3 for loads, 3'b010 for fetch.
//   - register mem_rdata at the closing posedge.
//  ACCESS (exactly 1 cycle), store:
//   - drive mem_write=1, mem_func3=d_func3, mem_wdata=d_wdata.
//   - memory commits at the closing posedge.
//  RESP (exactly 1 cycle):
//   - pulse the matching ready, plus err if the access was rejected.
//   - requests are ignored in RESP; next state is always IDLE.
//  Latency: request seen at edge N -> ready high in cycle N+2, error path in cycle N+1.
//   - initiation interval is 3 cycles, error path 2.
//  mem_read/mem_write are 0 outside ACCESS and are never both 1.
//   - mem_addr/mem_func3/mem_wdata are 0 outside ACCESS.
//  d_err conditions:
//   - funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores.
//   - halfword with addr[0]=1, or word with addr[1:0]!=0.
//   - addr[31:ADDR_W]!=0, or addr+size-1 beyond 2**ADDR_W-1 (no wrap-around).
//  if_err conditions: if_addr[1:0]!=0 or if_addr[31:ADDR_W]!=0.
//  Both requests present in IDLE: data served first; if_req stays held and is served on the next IDLE.
//  A request dropped before its ready is a core protocol violation; the in-flight access still completes.
//  Reset during ACCESS:
//   - mem_write drops immediately and the store is not committed.
//   - no ready pulse follows; the core must reissue.
// STRUCTURE
//  Shared package mem_pkg:
//   - funct3 constants F3_LB..F3_LHU, F3_SB/SH/SW, F3_FETCH=3'b010.
//   - FSM state encoding.
//  Sub-module mem_align_check (combinational):
//   - inputs addr, func3, is_store.
//   - outputs ok and size, reused for fetch with func3=3'b010.
// TESTING
//  - Reset with a behavioural Memory model.
//    if_req, if_addr=0 -> mem_read=1 and mem_func3=010 for one cycle; if_ready at +2; if_instr = word 0.
//  - d_req, d_we=1, func3=010, addr=0x80, wdata=32'hDEADBEEF -> one mem_write cycle.
//    Then a load with func3=000 at 0x83 -> d_rdata=32'hFFFFFFDE; func3=100 -> 32'h000000DE.
//  - if_req and d_req (lw 0x80) in the same cycle -> data served first (d_ready at +2).
//    Fetch ACCESS follows; if_ready 3 cycles after d_ready.
//  - sh at 0x81, lw at 0x82, lw at 0x100, func3=011 -> d_err and d_ready at +1.
//    mem_read=mem_write=0 throughout; memory unchanged.
//  - lw at 0xFC passes; lw at 0xFD errs; fetch at if_addr=0x6 -> if_err.
//  - rst low during store ACCESS (sw 0x90, 32'h12345678) -> mem_write drops at once; no d_ready.
//    A later lw 0x90 returns the old value.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 constants, FSM encoding and access-size helper
package mem_pkg;

    localparam logic [2:0] F3_LB    = 3'b000;
    localparam logic [2:0] F3_LH    = 3'b001;
    localparam logic [2:0] F3_LW    = 3'b010;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_LHU   = 3'b101;
    localparam logic [2:0] F3_SB    = 3'b000;
    localparam logic [2:0] F3_SH    = 3'b001;
    localparam logic [2:0] F3_SW    = 3'b010;
    localparam logic [2:0] F3_FETCH = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_check.sv
// rtl/mem_align_check.sv - funct3 legality, alignment and range check for one access
module mem_align_check
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [31:0] addr,
    input  logic [2:0]  func3,
    input  logic        is_store,
    output logic        ok,
    output logic [2:0]  size
);

    logic          f3_ok;
    logic          aligned;
    logic          hi_zero;
    logic [ADDR_W:0] last_byte;

    always_comb begin
        size = size_of(func3);

        if (is_store)
            f3_ok = (func3 == F3_SB) || (func3 == F3_SH) || (func3 == F3_SW);
        else
            f3_ok = (func3 == F3_LB) || (func3 == F3_LH) || (func3 == F3_LW) ||
                    (func3 == F3_LBU) || (func3 == F3_LHU);

        case (func3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        hi_zero = (addr[31:ADDR_W] == '0);

        // Carry out of the last byte address means the access would wrap past the top.
        last_byte = {1'b0, addr[ADDR_W-1:0]} + {{(ADDR_W-2){1'b0}}, size - 3'd1};

        ok = f3_ok && aligned && hi_zero && !last_byte[ADDR_W];
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - arbitrates fetch and load/store onto the single memory port
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_err,
    output logic [31:0]       if_instr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t      state;
    logic        cur_data;
    logic        cur_we;

    logic [31:0] chk_addr;
    logic [2:0]  chk_func3;
    logic        chk_store;
    logic        chk_ok;
    logic [2:0]  chk_size;
    logic        unused_size;

    // Data side wins arbitration: it belongs to the older instruction in flight.
    assign chk_addr    = d_req ? d_addr : if_addr;
    assign chk_func3   = d_req ? d_func3 : F3_FETCH;
    assign chk_store   = d_req & d_we;
    assign unused_size = ^chk_size;

    mem_align_check #(.ADDR_W(ADDR_W)) u_check (
        .addr     (chk_addr),
        .func3    (chk_func3),
        .is_store (chk_store),
        .ok       (chk_ok),
        .size     (chk_size)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cur_data  <= 1'b0;
            cur_we    <= 1'b0;
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            if_instr  <= '0;
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_func3 <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_req || if_req) begin
                        cur_data <= d_req;
                        cur_we   <= chk_store;
                        if (chk_ok) begin
                            state     <= ST_ACCESS;
                            mem_read  <= ~chk_store;
                            mem_write <= chk_store;
                            mem_func3 <= chk_func3;
                            mem_addr  <= chk_addr[ADDR_W-1:0];
                            mem_wdata <= chk_store ? d_wdata : '0;
                        end else begin
                            // Rejected: answer straight away, memory is never touched.
                            state    <= ST_RESP;
                            d_ready  <= d_req;
                            d_err    <= d_req;
                            if_ready <= ~d_req;
                            if_err   <= ~d_req;
                        end
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_RESP;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_func3 <= '0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (cur_data) begin
                        d_ready <= 1'b1;
                        d_err   <= 1'b0;
                        if (!cur_we)
                            d_rdata <= mem_rdata;
                    end else begin
                        if_ready <= 1'b1;
                        if_err   <= 1'b0;
                        if_instr <= mem_rdata;
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    if_err <= 1'b0;
                    d_err  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
